// File: rtl/write_back_pkg.sv
// Shared definitions for the writeback stage: selector bit positions, PC step,
// FSM state encodings and the latched commit request.
package write_back_pkg;

    localparam int WSEL_PC  = 2;
    localparam int WSEL_REG = 1;
    localparam int WSEL_FLT = 0;

    localparam logic [31:0] PC_STEP = 32'h4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    typedef struct packed {
        logic [2:0]  wsel;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] pc_tgt;
        logic [31:0] cur_pc;
        logic        stall;
    } wb_req_t;

endpackage

// File: rtl/write_back_if.sv
// Execute-result, decode read-port and fetch handshake bundle of the writeback stage.
interface write_back_if;
    logic        enable;
    logic [2:0]  wselector;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc_in;
    logic [31:0] cur_pc;
    logic        stall;
    logic [4:0]  rs_no;
    logic [4:0]  rt_no;
    logic        fmode1;
    logic        fmode2;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc_next;
    logic        done;

    modport master (
        output enable, wselector, data, rd, pc_in, cur_pc, stall,
        output rs_no, rt_no, fmode1, fmode2,
        input  rs, rt, pc_next, done
    );

    modport slave (
        input  enable, wselector, data, rd, pc_in, cur_pc, stall,
        input  rs_no, rt_no, fmode1, fmode2,
        output rs, rt, pc_next, done
    );
endinterface

// File: rtl/write_back_regfile_2r1w.sv
// NREG x 32 register file: two asynchronous read ports, one synchronous write port.
// ZERO_REG0=1 makes entry 0 a constant zero (writes dropped, reads return 0).
module regfile_2r1w #(
    parameter int NREG      = 32,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && !(ZERO_REG0 && waddr == 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (ZERO_REG0 && raddr_a == 5'd0) ? 32'h0 : mem[raddr_a];
    assign rdata_b = (ZERO_REG0 && raddr_b == 5'd0) ? 32'h0 : mem[raddr_b];

endmodule

// File: rtl/write_back.sv
// Writeback stage: commits execute results into GPR/FPR and produces the next fetch PC.
// Optional `WB_BYPASS_EN forwards the pending write to the read ports during COMMIT.
module write_back
    import write_back_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          NREG     = 32
) (
    input  logic         clk,
    input  logic         rst,
    write_back_if.slave  wb
);

    logic [0:0]  state;
    wb_req_t     req_p1;
    logic [31:0] pc_next_p2;
    logic        commit;
    logic        wr_en;
    logic        gpr_we;
    logic        fpr_we;
    logic [31:0] gpr_a, gpr_b, fpr_a, fpr_b;
    logic [31:0] file_a, file_b;

    function automatic logic [31:0] next_pc(input wb_req_t r);
        if (r.stall)
            return r.cur_pc;
        else if (r.wsel[WSEL_PC])
            return r.pc_tgt;
        else
            return r.cur_pc + PC_STEP;
    endfunction

    // A reset landing in COMMIT must cancel both the write and the done pulse.
    assign commit = (state == ST_COMMIT) && !rst;
    assign wr_en  = commit && !req_p1.stall && req_p1.wsel[WSEL_REG];
    assign gpr_we = wr_en && !req_p1.wsel[WSEL_FLT];
    assign fpr_we = wr_en &&  req_p1.wsel[WSEL_FLT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc_next_p2 <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb.enable)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    state      <= ST_IDLE;
                    pc_next_p2 <= next_pc(req_p1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- stage p1: latch the execute result while IDLE ----
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wb.enable) begin
            req_p1 <= {wb.wselector, wb.data, wb.rd, wb.pc_in & 32'hFFFF_FFFC,
                       wb.cur_pc, wb.stall};
        end
    end

    // ---- stage p2: register-file commit ----
    regfile_2r1w #(.NREG(NREG), .ZERO_REG0(1'b1)) u_gpr (
        .clk     (clk),
        .rst     (rst),
        .we      (gpr_we),
        .waddr   (req_p1.rd),
        .wdata   (req_p1.data),
        .raddr_a (wb.rs_no),
        .raddr_b (wb.rt_no),
        .rdata_a (gpr_a),
        .rdata_b (gpr_b)
    );

    regfile_2r1w #(.NREG(NREG), .ZERO_REG0(1'b0)) u_fpr (
        .clk     (clk),
        .rst     (rst),
        .we      (fpr_we),
        .waddr   (req_p1.rd),
        .wdata   (req_p1.data),
        .raddr_a (wb.rs_no),
        .raddr_b (wb.rt_no),
        .rdata_a (fpr_a),
        .rdata_b (fpr_b)
    );

    assign file_a = wb.fmode1 ? fpr_a : gpr_a;
    assign file_b = wb.fmode2 ? fpr_b : gpr_b;

`ifdef WB_BYPASS_EN
    function automatic logic byp_hit(input logic fmode, input logic [4:0] idx,
                                     input wb_req_t r);
        return (fmode == r.wsel[WSEL_FLT]) && (idx == r.rd) &&
               ((idx != 5'd0) || r.wsel[WSEL_FLT]);
    endfunction

    assign wb.rs = (wr_en && byp_hit(wb.fmode1, wb.rs_no, req_p1)) ? req_p1.data : file_a;
    assign wb.rt = (wr_en && byp_hit(wb.fmode2, wb.rt_no, req_p1)) ? req_p1.data : file_b;
`else
    assign wb.rs = file_a;
    assign wb.rt = file_b;
`endif

    assign wb.pc_next = pc_next_p2;
    assign wb.done    = commit;

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back (RESET_PC overridden to 32'h1000).
module tb_write_back;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    write_back_if wb ();

    write_back #(.RESET_PC(RST_PC), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_a(input string tag, input logic f, input logic [4:0] idx,
                          input logic [31:0] exp);
        wb.fmode1 = f;
        wb.rs_no  = idx;
        #1;
        check(tag, wb.rs, exp);
    endtask

    task automatic read_b(input string tag, input logic f, input logic [4:0] idx,
                          input logic [31:0] exp);
        wb.fmode2 = f;
        wb.rt_no  = idx;
        #1;
        check(tag, wb.rt, exp);
    endtask

    // Drives one execute result; returns early in the COMMIT cycle.
    task automatic issue(input logic [2:0] ws, input logic [31:0] d, input logic [4:0] r,
                         input logic [31:0] pin, input logic [31:0] cpc, input logic st);
        @(posedge clk);
        #1;
        wb.enable    = 1'b1;
        wb.wselector = ws;
        wb.data      = d;
        wb.rd        = r;
        wb.pc_in     = pin;
        wb.cur_pc    = cpc;
        wb.stall     = st;
        #1;
        check("done_idle", 32'(wb.done), 32'h0);
        @(posedge clk);
        #1;
        wb.enable = 1'b0;
        check("done_commit", 32'(wb.done), 32'h1);
    endtask

    task automatic after_commit();
        @(posedge clk);
        #1;
        check("done_after", 32'(wb.done), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        wb.enable    = 1'b0;
        wb.wselector = 3'b000;
        wb.data      = '0;
        wb.rd        = '0;
        wb.pc_in     = '0;
        wb.cur_pc    = '0;
        wb.stall     = 1'b0;
        wb.rs_no     = '0;
        wb.rt_no     = '0;
        wb.fmode1    = 1'b0;
        wb.fmode2    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_pc", wb.pc_next, RST_PC);
        check("rst_done", 32'(wb.done), 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_a("rst_gpr", 1'b0, 5'(i), 32'h0);
            read_b("rst_fpr", 1'b1, 5'(i), 32'h0);
        end

        // GPR write, sequential PC
        issue(3'b010, 32'hDEAD_BEEF, 5'd5, 32'h0, 32'h100, 1'b0);
        after_commit();
        check("gpr5_pc", wb.pc_next, 32'h104);
        read_a("gpr5", 1'b0, 5'd5, 32'hDEAD_BEEF);
        read_a("fpr5_untouched", 1'b1, 5'd5, 32'h0);

        // FPR[0] is writable
        issue(3'b011, 32'h3F80_0000, 5'd0, 32'h0, 32'h104, 1'b0);
        after_commit();
        check("fpr0_pc", wb.pc_next, 32'h108);
        read_b("fpr0", 1'b1, 5'd0, 32'h3F80_0000);

        // GPR[0] stays zero
        issue(3'b010, 32'h1234_5678, 5'd0, 32'h0, 32'h108, 1'b0);
        after_commit();
        check("gpr0_pc", wb.pc_next, 32'h10C);
        read_a("gpr0", 1'b0, 5'd0, 32'h0);

        // JAL: link write plus aligned PC load
        issue(3'b110, 32'h208, 5'd31, 32'h403, 32'h204, 1'b0);
        after_commit();
        check("jal_pc", wb.pc_next, 32'h400);
        read_a("jal_link", 1'b0, 5'd31, 32'h208);

        // Stall suppresses the write and re-issues cur_pc
        issue(3'b010, 32'h33, 5'd3, 32'h0, 32'h400, 1'b0);
        after_commit();
        check("gpr3_pc", wb.pc_next, 32'h404);
        issue(3'b010, 32'hBAD, 5'd3, 32'h0, 32'h50, 1'b1);
        after_commit();
        check("stall_pc", wb.pc_next, 32'h50);
        read_a("stall_gpr3", 1'b0, 5'd3, 32'h33);

        // No-write selector with PC wrap
        issue(3'b000, 32'h999, 5'd6, 32'h0, 32'hFFFF_FFFC, 1'b0);
        after_commit();
        check("wrap_pc", wb.pc_next, 32'h0);
        read_a("nowr_gpr6", 1'b0, 5'd6, 32'h0);
        read_a("nowr_fpr6", 1'b1, 5'd6, 32'h0);

        // Enable held into COMMIT with new fields is ignored
        @(posedge clk);
        #1;
        wb.enable    = 1'b1;
        wb.wselector = 3'b010;
        wb.data      = 32'h88;
        wb.rd        = 5'd8;
        wb.cur_pc    = 32'h60;
        wb.stall     = 1'b0;
        @(posedge clk);
        #1;
        wb.data   = 32'hAAAA;
        wb.rd     = 5'd9;
        wb.cur_pc = 32'h70;
        check("hold_done", 32'(wb.done), 32'h1);
        @(posedge clk);
        #1;
        wb.enable = 1'b0;
        check("hold_pc", wb.pc_next, 32'h64);
        read_a("hold_gpr8", 1'b0, 5'd8, 32'h88);
        @(posedge clk);
        #1;
        check("hold_no_redo", 32'(wb.done), 32'h0);
        read_a("hold_gpr9", 1'b0, 5'd9, 32'h0);
        check("hold_pc2", wb.pc_next, 32'h64);

        // Read of the pending FPR write during COMMIT
        issue(3'b011, 32'h4049_0FDB, 5'd7, 32'h0, 32'h64, 1'b0);
`ifdef WB_BYPASS_EN
        read_a("byp_fpr7", 1'b1, 5'd7, 32'h4049_0FDB);
`else
        read_a("byp_fpr7", 1'b1, 5'd7, 32'h0);
`endif
        after_commit();
        read_a("fpr7", 1'b1, 5'd7, 32'h4049_0FDB);

        // Reset during COMMIT drops the write and clears state
        issue(3'b010, 32'h1010, 5'd10, 32'h0, 32'h80, 1'b0);
        rst = 1'b1;
        #1;
        check("rstc_done", 32'(wb.done), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstc_pc", wb.pc_next, RST_PC);
        read_a("rstc_gpr10", 1'b0, 5'd10, 32'h0);
        read_a("rstc_gpr5", 1'b0, 5'd5, 32'h0);
        @(posedge clk);
        #1;
        check("rstc_done2", 32'(wb.done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
